// File: rtl/arbitrated_memory.sv
// rtl/arbitrated_memory.sv - single-port RAM shared by two valid/ready requesters
//
// Purpose: one RAM access per clock. Two requesters reach it through a
// combinational arbiter that is either round-robin or fixed-priority with
// anti-starvation. Writes have byte-lane enables. Read data is registered
// twice: the RAM word is captured at the accept edge, and it reaches
// DATA_OUT_n with a one-cycle RVALID_n pulse on the following edge.
//
// Ports (n = 0, 1):
//   CLK          clock, rising edge
//   RST          synchronous active-high reset
//   VALID_n      request present
//   READY_n      grant (combinational from VALID_0/1 and registered state)
//   ADDRESS_n    word address
//   DATA_IN_n    write data
//   BE_n         byte-lane write enables (ignored on reads)
//   WRb_n        0 = write, 1 = read
//   DATA_OUT_n   registered read data, held until the next read completes
//   RVALID_n     one-cycle pulse when DATA_OUT_n is updated
module arbitrated_memory #(
  parameter int BITS          = 16,
  parameter int ADDRESS_BITS  = 16,
  parameter int PRIORITY_MODE = 0,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    VALID_0,
  output logic                    READY_0,
  input  logic [ADDRESS_BITS-1:0] ADDRESS_0,
  input  logic [BITS-1:0]         DATA_IN_0,
  input  logic [BITS/8-1:0]       BE_0,
  input  logic                    WRb_0,
  output logic [BITS-1:0]         DATA_OUT_0,
  output logic                    RVALID_0,
  input  logic                    VALID_1,
  output logic                    READY_1,
  input  logic [ADDRESS_BITS-1:0] ADDRESS_1,
  input  logic [BITS-1:0]         DATA_IN_1,
  input  logic [BITS/8-1:0]       BE_1,
  input  logic                    WRb_1,
  output logic [BITS-1:0]         DATA_OUT_1,
  output logic                    RVALID_1
);

  localparam int         LANES = BITS / 8;
  localparam int         DEPTH = 1 << ADDRESS_BITS;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  // Port that won the most recent accept; the other port wins a tie in
  // round-robin mode. Resets to 1 so port 0 wins the first contention.
  logic       last;
  logic [7:0] starve_cnt;
  logic       grant_0;
  logic       grant_1;

  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (!RST) begin
      if (VALID_0 && VALID_1) begin
        if (PRIORITY_MODE == 0) begin
          grant_0 = last;
          grant_1 = !last;
        end else begin
          grant_1 = (starve_cnt == LIMIT);
          grant_0 = !grant_1;
        end
      end else begin
        grant_0 = VALID_0;
        grant_1 = VALID_1;
      end
    end
  end

  assign READY_0 = grant_0;
  assign READY_1 = grant_1;

  // Selected access for this cycle (at most one grant is ever high)
  logic                    acc;
  logic                    acc_port;
  logic                    acc_read;
  logic [ADDRESS_BITS-1:0] sel_addr;
  logic [BITS-1:0]         sel_data;
  logic [LANES-1:0]        sel_be;

  assign acc      = grant_0 | grant_1;
  assign acc_port = grant_1;
  assign acc_read = grant_1 ? WRb_1     : WRb_0;
  assign sel_addr = grant_1 ? ADDRESS_1 : ADDRESS_0;
  assign sel_data = grant_1 ? DATA_IN_1 : DATA_IN_0;
  assign sel_be   = grant_1 ? BE_1      : BE_0;

  // RAM array and its synchronous read register; contents are never reset
  logic [BITS-1:0] mem [DEPTH];
  logic [BITS-1:0] rd_word;

  always_ff @(posedge CLK) begin
    if (acc) begin
      if (acc_read) begin
        rd_word <= mem[sel_addr];
      end else begin
        for (int k = 0; k < LANES; k++) begin
          if (sel_be[k]) begin
            mem[sel_addr][8*k +: 8] <= sel_data[8*k +: 8];
          end
        end
      end
    end
  end

  // rd_pend marks that rd_word holds a read accepted on the previous edge;
  // a reset on the completion edge drops it without pulsing RVALID.
  logic rd_pend;
  logic rd_port;

  always_ff @(posedge CLK) begin
    if (RST) begin
      last       <= 1'b1;
      starve_cnt <= 8'd0;
      rd_pend    <= 1'b0;
      rd_port    <= 1'b0;
      RVALID_0   <= 1'b0;
      RVALID_1   <= 1'b0;
      DATA_OUT_0 <= '0;
      DATA_OUT_1 <= '0;
    end else begin
      if (acc) begin
        last <= acc_port;
      end

      if (PRIORITY_MODE == 0 || !VALID_1 || grant_1) begin
        starve_cnt <= 8'd0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 8'd1;
      end

      rd_pend  <= acc & acc_read;
      rd_port  <= acc_port;
      RVALID_0 <= rd_pend & !rd_port;
      RVALID_1 <= rd_pend & rd_port;
      if (rd_pend && !rd_port) begin
        DATA_OUT_0 <= rd_word;
      end
      if (rd_pend && rd_port) begin
        DATA_OUT_1 <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_arbitrated_memory.sv
// tb/tb_arbitrated_memory.sv - self-checking bench for arbitrated_memory
module tb_arbitrated_memory;

  localparam int BITS = 16;
  localparam int AW   = 8;
  localparam int NB   = BITS / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      valid [2];
  logic [1:0]      wrb   [2];
  logic [AW-1:0]   addr  [2][2];
  logic [BITS-1:0] din   [2][2];
  logic [NB-1:0]   be    [2][2];
  wire  [1:0]      ready  [2];
  wire  [1:0]      rvalid [2];
  wire  [BITS-1:0] dout   [2][2];

  // Instance 0: round-robin. Instance 1: fixed priority, starve limit 3.
  for (genvar g = 0; g < 2; g++) begin : gen_dut
    arbitrated_memory #(
      .BITS(BITS), .ADDRESS_BITS(AW), .PRIORITY_MODE(g), .STARVE_LIMIT(3)
    ) dut (
      .CLK(clk), .RST(rst),
      .VALID_0(valid[g][0]), .READY_0(ready[g][0]), .ADDRESS_0(addr[g][0]),
      .DATA_IN_0(din[g][0]), .BE_0(be[g][0]), .WRb_0(wrb[g][0]),
      .DATA_OUT_0(dout[g][0]), .RVALID_0(rvalid[g][0]),
      .VALID_1(valid[g][1]), .READY_1(ready[g][1]), .ADDRESS_1(addr[g][1]),
      .DATA_IN_1(din[g][1]), .BE_1(be[g][1]), .WRb_1(wrb[g][1]),
      .DATA_OUT_1(dout[g][1]), .RVALID_1(rvalid[g][1])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: memory image, who was served last, how long port 1 waited
  logic [BITS-1:0] mem_m        [2][256];
  bit              known_m      [2][256];
  int              last_m       [2];
  int              denied_m     [2];
  bit              pend_m       [2];
  int              pend_port_m  [2];
  logic [BITS-1:0] pend_data_m  [2];
  bit              pend_known_m [2];
  logic [1:0]      exp_rv       [2];
  logic [BITS-1:0] exp_dout     [2][2];
  bit              dout_known   [2][2];
  logic [1:0]      g_m          [2];

  function automatic logic [1:0] model_grant(input int d);
    if (rst) return 2'b00;
    if (valid[d] != 2'b11) return valid[d];
    if (d == 0) return (last_m[d] == 0) ? 2'b10 : 2'b01;
    return (denied_m[d] >= 3) ? 2'b10 : 2'b01;
  endfunction

  task automatic model_edge(input int d, input logic [1:0] g);
    int p;
    if (rst) begin
      exp_rv[d] = 2'b00;
      for (int q = 0; q < 2; q++) begin
        exp_dout[d][q]   = '0;
        dout_known[d][q] = 1'b1;
      end
      pend_m[d]   = 1'b0;
      last_m[d]   = 1;
      denied_m[d] = 0;
      return;
    end
    exp_rv[d] = 2'b00;
    if (pend_m[d]) begin
      exp_rv[d][pend_port_m[d]]       = 1'b1;
      exp_dout[d][pend_port_m[d]]     = pend_data_m[d];
      dout_known[d][pend_port_m[d]]   = pend_known_m[d];
    end
    pend_m[d] = 1'b0;
    if (g != 2'b00) begin
      p = g[1] ? 1 : 0;
      last_m[d] = p;
      if (wrb[d][p]) begin
        pend_m[d]       = 1'b1;
        pend_port_m[d]  = p;
        pend_data_m[d]  = mem_m[d][addr[d][p]];
        pend_known_m[d] = known_m[d][addr[d][p]];
      end else begin
        for (int k = 0; k < NB; k++)
          if (be[d][p][k]) mem_m[d][addr[d][p]][8*k +: 8] = din[d][p][8*k +: 8];
        if (be[d][p] == {NB{1'b1}}) known_m[d][addr[d][p]] = 1'b1;
      end
    end
    if (valid[d][1] && !g[1]) denied_m[d]++;
    else denied_m[d] = 0;
  endtask

  task automatic model_tick(input bit do_check);
    logic [1:0] g;
    for (int d = 0; d < 2; d++) begin
      g = model_grant(d);
      g_m[d] = g;
      if (do_check) chk($sformatf("ready dut%0d", d), 32'(ready[d]), 32'(g));
      model_edge(d, g);
    end
  endtask

  task automatic post_check();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rvalid dut%0d", d), 32'(rvalid[d]), 32'(exp_rv[d]));
      for (int p = 0; p < 2; p++)
        if (dout_known[d][p])
          chk($sformatf("dout dut%0d port%0d", d, p), 32'(dout[d][p]), 32'(exp_dout[d][p]));
    end
  endtask

  task automatic set_req(input int d, input int p, input logic v, input logic rd,
                         input logic [AW-1:0] a, input logic [BITS-1:0] dat,
                         input logic [NB-1:0] b);
    valid[d][p] = v;
    wrb[d][p]   = rd;
    addr[d][p]  = a;
    din[d][p]   = dat;
    be[d][p]    = b;
  endtask

  task automatic model_cycle();
    @(negedge clk);
    model_tick(1);
    @(posedge clk);
    #1;
    post_check();
  endtask

  // Vector table for instance 0: inputs per cycle, expected grant during the
  // cycle, expected RVALID/DATA_OUT just after the closing edge.
  typedef struct {
    logic [1:0]      v;
    logic [1:0]      rd;
    logic [AW-1:0]   a0;
    logic [BITS-1:0] d0;
    logic [NB-1:0]   b0;
    logic [AW-1:0]   a1;
    logic [BITS-1:0] d1;
    logic [NB-1:0]   b1;
    logic [1:0]      er;
    logic [1:0]      erv;
    logic [BITS-1:0] eo0;
    logic [BITS-1:0] eo1;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] rd,
                              input logic [AW-1:0] a0, input logic [BITS-1:0] d0, input logic [NB-1:0] b0,
                              input logic [AW-1:0] a1, input logic [BITS-1:0] d1, input logic [NB-1:0] b1,
                              input logic [1:0] er, input logic [1:0] erv,
                              input logic [BITS-1:0] eo0, input logic [BITS-1:0] eo1);
    vec_t r;
    r.v = v; r.rd = rd; r.a0 = a0; r.d0 = d0; r.b0 = b0;
    r.a1 = a1; r.d1 = d1; r.b1 = b1; r.er = er; r.erv = erv; r.eo0 = eo0; r.eo1 = eo1;
    return r;
  endfunction

  logic [1:0] starve_grant [8];
  int         starve_exp   [8];

  initial begin
    tbl[0]  = mk(2'b01, 2'b00, 8'h10, 16'hBEEF, 2'b11, 8'h00, 16'h0000, 2'b00, 2'b01, 2'b00, 16'h0000, 16'h0000);
    tbl[1]  = mk(2'b01, 2'b01, 8'h10, 16'h0000, 2'b00, 8'h00, 16'h0000, 2'b00, 2'b01, 2'b00, 16'h0000, 16'h0000);
    tbl[2]  = mk(2'b00, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00, 16'h0000, 2'b00, 2'b00, 2'b01, 16'hBEEF, 16'h0000);
    tbl[3]  = mk(2'b00, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00, 16'h0000, 2'b00, 2'b00, 2'b00, 16'hBEEF, 16'h0000);
    tbl[4]  = mk(2'b01, 2'b00, 8'h04, 16'h1234, 2'b11, 8'h00, 16'h0000, 2'b00, 2'b01, 2'b00, 16'hBEEF, 16'h0000);
    tbl[5]  = mk(2'b01, 2'b00, 8'h04, 16'hABCD, 2'b10, 8'h00, 16'h0000, 2'b00, 2'b01, 2'b00, 16'hBEEF, 16'h0000);
    tbl[6]  = mk(2'b01, 2'b01, 8'h04, 16'h0000, 2'b00, 8'h00, 16'h0000, 2'b00, 2'b01, 2'b00, 16'hBEEF, 16'h0000);
    tbl[7]  = mk(2'b01, 2'b00, 8'h04, 16'hFFFF, 2'b00, 8'h00, 16'h0000, 2'b00, 2'b01, 2'b01, 16'hAB34, 16'h0000);
    tbl[8]  = mk(2'b01, 2'b01, 8'h04, 16'h0000, 2'b00, 8'h00, 16'h0000, 2'b00, 2'b01, 2'b00, 16'hAB34, 16'h0000);
    tbl[9]  = mk(2'b01, 2'b00, 8'h20, 16'h5555, 2'b11, 8'h00, 16'h0000, 2'b00, 2'b01, 2'b01, 16'hAB34, 16'h0000);
    tbl[10] = mk(2'b10, 2'b10, 8'h00, 16'h0000, 2'b00, 8'h20, 16'h0000, 2'b00, 2'b10, 2'b00, 16'hAB34, 16'h0000);
    tbl[11] = mk(2'b00, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00, 16'h0000, 2'b00, 2'b00, 2'b10, 16'hAB34, 16'h5555);
    tbl[12] = mk(2'b11, 2'b00, 8'h01, 16'h1111, 2'b11, 8'h02, 16'h2222, 2'b11, 2'b01, 2'b00, 16'hAB34, 16'h5555);
    tbl[13] = mk(2'b10, 2'b00, 8'h01, 16'h1111, 2'b11, 8'h02, 16'h2222, 2'b11, 2'b10, 2'b00, 16'hAB34, 16'h5555);
    tbl[14] = mk(2'b11, 2'b11, 8'h01, 16'h0000, 2'b00, 8'h02, 16'h0000, 2'b00, 2'b01, 2'b00, 16'hAB34, 16'h5555);
    tbl[15] = mk(2'b11, 2'b11, 8'h01, 16'h0000, 2'b00, 8'h02, 16'h0000, 2'b00, 2'b10, 2'b01, 16'h1111, 16'h5555);
    tbl[16] = mk(2'b11, 2'b11, 8'h01, 16'h0000, 2'b00, 8'h02, 16'h0000, 2'b00, 2'b01, 2'b10, 16'h1111, 16'h2222);
    tbl[17] = mk(2'b11, 2'b11, 8'h01, 16'h0000, 2'b00, 8'h02, 16'h0000, 2'b00, 2'b10, 2'b01, 16'h1111, 16'h2222);
    tbl[18] = mk(2'b00, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00, 16'h0000, 2'b00, 2'b00, 2'b10, 16'h1111, 16'h2222);
    tbl[19] = mk(2'b00, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h1111, 16'h2222);

    starve_grant = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
    starve_exp   = '{0, 1, 2, 3, 0, 1, 2, 3};

    for (int d = 0; d < 2; d++) begin
      last_m[d] = 1; denied_m[d] = 0; pend_m[d] = 1'b0; g_m[d] = 2'b00; exp_rv[d] = 2'b00;
      for (int p = 0; p < 2; p++) begin
        set_req(d, p, 1'b1, 1'b0, 8'h04, 16'hDEAD, 2'b11);
        exp_dout[d][p] = '0; dout_known[d][p] = 1'b0;
      end
    end

    // Reset with all requesters valid: no grant, outputs cleared
    rst = 1'b1;
    repeat (2) model_cycle();
    rst = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) valid[d][p] = 1'b0;

    // Table-driven directed sequence on the round-robin instance
    for (int i = 0; i < 20; i++) begin
      set_req(0, 0, tbl[i].v[0], tbl[i].rd[0], tbl[i].a0, tbl[i].d0, tbl[i].b0);
      set_req(0, 1, tbl[i].v[1], tbl[i].rd[1], tbl[i].a1, tbl[i].d1, tbl[i].b1);
      @(negedge clk);
      chk($sformatf("tbl%0d ready", i), 32'(ready[0]), 32'(tbl[i].er));
      model_tick(0);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d rvalid", i), 32'(rvalid[0]), 32'(tbl[i].erv));
      chk($sformatf("tbl%0d dout0", i), 32'(dout[0][0]), 32'(tbl[i].eo0));
      chk($sformatf("tbl%0d dout1", i), 32'(dout[0][1]), 32'(tbl[i].eo1));
    end

    // Reset one cycle after a port-1 read accept
    set_req(0, 1, 1'b0, 1'b1, 8'h02, 16'h0000, 2'b00);
    set_req(0, 0, 1'b1, 1'b0, 8'h03, 16'h7777, 2'b11);
    model_cycle();
    set_req(0, 0, 1'b0, 1'b1, 8'h03, 16'h0000, 2'b00);
    set_req(0, 1, 1'b1, 1'b1, 8'h02, 16'h0000, 2'b00);
    @(negedge clk);
    chk("rst seq read grant", 32'(ready[0]), 32'(2'b10));
    model_tick(0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_req(0, 0, 1'b1, 1'b0, 8'h03, 16'hDEAD, 2'b11);
    @(negedge clk);
    chk("rst seq ready during reset", 32'(ready[0]), 32'(2'b00));
    model_tick(0);
    @(posedge clk);
    #1;
    chk("rst seq rvalid suppressed", 32'(rvalid[0]), 32'(2'b00));
    chk("rst seq dout1 cleared", 32'(dout[0][1]), 32'(16'h0000));
    rst = 1'b0;
    set_req(0, 1, 1'b0, 1'b1, 8'h02, 16'h0000, 2'b00);
    set_req(0, 0, 1'b1, 1'b0, 8'h30, 16'h0000, 2'b11);
    model_cycle();
    set_req(0, 0, 1'b0, 1'b0, 8'h30, 16'h0000, 2'b11);
    rst = 1'b1;
    model_cycle();
    rst = 1'b0;
    set_req(0, 0, 1'b1, 1'b0, 8'h31, 16'h0000, 2'b00);
    set_req(0, 1, 1'b1, 1'b0, 8'h32, 16'h0000, 2'b00);
    @(negedge clk);
    chk("first contention after reset", 32'(ready[0]), 32'(2'b01));
    model_tick(0);
    @(posedge clk);
    #1;
    set_req(0, 1, 1'b0, 1'b0, 8'h32, 16'h0000, 2'b00);
    set_req(0, 0, 1'b1, 1'b1, 8'h03, 16'h0000, 2'b00);
    model_cycle();
    set_req(0, 0, 1'b0, 1'b1, 8'h03, 16'h0000, 2'b00);
    model_cycle();
    chk("no write during reset", 32'(dout[0][0]), 32'(16'h7777));

    // Fixed-priority starvation on instance 1 (BE=0 writes are no-ops)
    set_req(1, 0, 1'b1, 1'b0, 8'h40, 16'h0000, 2'b00);
    set_req(1, 1, 1'b1, 1'b0, 8'h41, 16'h0000, 2'b00);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("starve%0d grant", i), 32'(ready[1]), 32'(starve_grant[i]));
      chk($sformatf("starve%0d count", i), 32'(gen_dut[1].dut.starve_cnt), 32'(starve_exp[i]));
      model_tick(0);
      @(posedge clk);
      #1;
    end
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) valid[d][p] = 1'b0;
    repeat (2) model_cycle();

    // Randomised traffic on both instances against the model
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          if (valid[d][p] && !g_m[d][p]) begin
            if ($urandom_range(0, 9) == 0) valid[d][p] = 1'b0;
          end else begin
            set_req(d, p, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 15)), BITS'($urandom), NB'($urandom));
          end
        end
      end
      model_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
